// File: rtl/pcs_tx_enc_pkg.sv
// Shared constants and block kind for the 64b/66b transmit encoder.
package pcs_tx_enc_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_TERM [0:7] = '{
        8'h87, 8'h99, 8'hAA, 8'hB4,
        8'hCC, 8'hD2, 8'hE1, 8'hFF
    };

    localparam logic [6:0] CC_IDLE = 7'h00;
    localparam logic [6:0] CC_ERR  = 7'h1E;

    typedef enum logic [2:0] {
        K_DATA,
        K_START,
        K_TERM,
        K_IDLE,
        K_ERR
    } kind_e;

endpackage

// File: rtl/pcs_tx_blk_fmt.sv
// Combinational block formatter: kind + collected bytes -> sync header and payload.
module pcs_tx_blk_fmt
    import pcs_tx_enc_pkg::*;
(
    input  kind_e       kind_i,
    input  logic [63:0] bytes_i,
    input  logic [2:0]  len_i,
    output logic [1:0]  head_o,
    output logic [63:0] data_o
);

    always_comb begin
        head_o = SYNC_CTRL;
        data_o = '0;
        unique case (kind_i)
            K_DATA: begin
                head_o = SYNC_DATA;
                data_o = bytes_i;
            end
            K_START: data_o = {bytes_i[63:8], BT_START};
            K_IDLE:  data_o = {{8{CC_IDLE}}, BT_IDLE};
            K_TERM: begin
                data_o[7:0] = BT_TERM[len_i];
                // terminate bytes shift up one lane behind the type byte
                for (int i = 1; i < 8; i++) begin
                    if (i <= int'(len_i)) begin
                        data_o[i*8 +: 8] = bytes_i[(i-1)*8 +: 8];
                    end
                end
            end
            default: data_o = {{8{CC_ERR}}, BT_IDLE};
        endcase
    end

endmodule

// File: rtl/pcs_tx_enc.sv
// Transmit PCS encoder: packs MAC beats into 64b/66b blocks and polices framing.
module pcs_tx_enc
    import pcs_tx_enc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int BLOCK_W     = 64,
    parameter int BEATS       = BLOCK_W / DATA_W,
    parameter int BLOCK_LEN_W = 4,
    parameter int LANE0_CNT_N = 1
) (
    input  logic                   clk,
    input  logic                   nreset,
    output logic                   mac_ready_o,
    input  logic                   mac_ctrl_v_i,
    input  logic [DATA_W-1:0]      mac_data_i,
    input  logic [LANE0_CNT_N-1:0] mac_start_i,
    input  logic                   mac_idle_i,
    input  logic                   mac_term_i,
    input  logic [BLOCK_LEN_W-1:0] mac_term_len_i,
    input  logic                   pcs_ready_i,
    output logic                   pcs_valid_o,
    output logic [1:0]             pcs_head_o,
    output logic [63:0]            pcs_data_o,
    output logic                   pcs_err_o
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]      cnt_q;
    logic [BLOCK_W-1:0] acc_q;
    logic [BLOCK_W-1:0] acc_d;
    kind_e              kind_q;
    kind_e              kind_b0;
    kind_e              kind_cur;
    kind_e              kind_out;
    logic [2:0]         len_q;
    logic [2:0]         len_cur;
    logic               in_q;
    logic               valid_q;
    logic [1:0]         head_q;
    logic [63:0]        data_q;
    logic               err_q;
    logic [1:0]         fmt_head;
    logic [63:0]        fmt_data;
    logic               first;
    logic               last;
    logic               fire;
    logic               ctl_flag;
    logic               len_bad;

    assign first = (cnt_q == '0);
    assign last  = (cnt_q == CW'(BEATS - 1));

    assign mac_ready_o = ~last | ~valid_q | pcs_ready_i;
    assign fire        = mac_ready_o & last;

    assign ctl_flag = mac_ctrl_v_i | mac_start_i[0] | mac_term_i;
    assign len_bad  = (mac_term_len_i > BLOCK_LEN_W'(7));

    always_comb begin
        acc_d = acc_q;
        acc_d[int'(cnt_q)*KEEP_W*8 +: DATA_W] = mac_data_i;
    end

    always_comb begin
        kind_b0 = K_ERR;
        unique case (1'b1)
            mac_idle_i & ~ctl_flag:               kind_b0 = K_IDLE;
            ~mac_ctrl_v_i & ~mac_idle_i:          kind_b0 = K_DATA;
            mac_ctrl_v_i & ~mac_idle_i
              & mac_start_i[0] & ~mac_term_i:     kind_b0 = K_START;
            mac_ctrl_v_i & ~mac_idle_i & ~len_bad
              & mac_term_i & ~mac_start_i[0]:     kind_b0 = K_TERM;
            default:                              kind_b0 = K_ERR;
        endcase
    end

    assign kind_cur = first ? kind_b0 : (ctl_flag ? K_ERR : kind_q);
    assign len_cur  = first ? mac_term_len_i[2:0] : len_q;

    always_comb begin
        kind_out = K_ERR;
        unique case (kind_cur)
            K_START: kind_out = in_q ? K_ERR : K_START;
            K_TERM:  kind_out = in_q ? K_TERM : K_ERR;
            K_DATA:  kind_out = in_q ? K_DATA : K_ERR;
            K_IDLE:  kind_out = in_q ? K_ERR : K_IDLE;
            default: kind_out = K_ERR;
        endcase
    end

    pcs_tx_blk_fmt u_fmt (
        .kind_i  (kind_out),
        .bytes_i (acc_d),
        .len_i   (len_cur),
        .head_o  (fmt_head),
        .data_o  (fmt_data)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            kind_q  <= K_IDLE;
            len_q   <= '0;
            in_q    <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (mac_ready_o) begin
                acc_q  <= acc_d;
                kind_q <= kind_cur;
                cnt_q  <= last ? '0 : cnt_q + 1'b1;
                if (first) begin
                    len_q <= mac_term_len_i[2:0];
                end
            end
            if (fire) begin
                in_q    <= (kind_out == K_START) | (kind_out == K_DATA);
                valid_q <= 1'b1;
                head_q  <= fmt_head;
                data_q  <= fmt_data;
                err_q   <= (kind_out == K_ERR);
            end else begin
                err_q <= 1'b0;
                if (pcs_ready_i) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign pcs_valid_o = valid_q;
    assign pcs_head_o  = head_q;
    assign pcs_data_o  = data_q;
    assign pcs_err_o   = err_q;

endmodule

// File: tb/tb_pcs_tx_enc.sv
// Directed bench for pcs_tx_enc: expected blocks are hand-encoded constants.
module tb_pcs_tx_enc;

    logic        clk = 1'b0;
    logic        nreset;
    logic        mac_ready_o;
    logic        mac_ctrl_v_i;
    logic [15:0] mac_data_i;
    logic [0:0]  mac_start_i;
    logic        mac_idle_i;
    logic        mac_term_i;
    logic [3:0]  mac_term_len_i;
    logic        pcs_ready_i;
    logic        pcs_valid_o;
    logic [1:0]  pcs_head_o;
    logic [63:0] pcs_data_o;
    logic        pcs_err_o;

    localparam logic [63:0] IDLE_BLK = 64'h1E;
    localparam logic [63:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E};
    localparam logic [63:0] SP       = 64'hD555555555555555;
    localparam logic [63:0] SP_ENC   = 64'hD555555555555578;
    localparam logic [63:0] D1       = 64'h0706050403020100;
    localparam logic [63:0] D2       = 64'h0F0E0D0C0B0A0908;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_beat = 0;
    int low_cnt = 0;
    logic        hold_q = 1'b0;
    logic [65:0] prev_out = '0;
    logic        cur_err = 1'b0;
    logic [66:0] exp_q[$];
    logic [66:0] got_q[$];

    always #5 clk = ~clk;

    pcs_tx_enc dut (
        .clk            (clk),
        .nreset         (nreset),
        .mac_ready_o    (mac_ready_o),
        .mac_ctrl_v_i   (mac_ctrl_v_i),
        .mac_data_i     (mac_data_i),
        .mac_start_i    (mac_start_i),
        .mac_idle_i     (mac_idle_i),
        .mac_term_i     (mac_term_i),
        .mac_term_len_i (mac_term_len_i),
        .pcs_ready_i    (pcs_ready_i),
        .pcs_valid_o    (pcs_valid_o),
        .pcs_head_o     (pcs_head_o),
        .pcs_data_o     (pcs_data_o),
        .pcs_err_o      (pcs_err_o)
    );

    task automatic chk(input string tag, input logic [66:0] got,
                       input logic [66:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic exp_blk(input logic [1:0] h, input logic [63:0] d,
                           input logic e);
        exp_q.push_back({e, h, d});
    endtask

    task automatic send_blk(input logic c, input logic s, input logic id,
                            input logic t, input logic [3:0] len,
                            input logic [63:0] d, input int bad,
                            input int nb);
        int n;
        for (int k = 0; k < nb; k++) begin
            mac_data_i     = d[k*16 +: 16];
            mac_idle_i     = id;
            mac_ctrl_v_i   = (k == 0 && c) || (k == bad);
            mac_start_i    = 1'((k == 0) && s);
            mac_term_i     = (k == 0 && t) || (k == bad);
            mac_term_len_i = len;
            cur_beat       = k;
            #1;
            n = 0;
            while (!mac_ready_o && n < 50) begin
                @(posedge clk);
                #2;
                n++;
            end
            if (n >= 50) chk("rdy_timeout", 67'(mac_ready_o), 67'(1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        mac_ctrl_v_i = 0; mac_start_i = 0; mac_term_i = 0;
        mac_idle_i = 1; mac_data_i = 0; mac_term_len_i = 0;
    endtask

    always @(posedge clk) begin
        if (nreset && pcs_valid_o && pcs_ready_i)
            got_q.push_back({cur_err, pcs_head_o, pcs_data_o});
    end

    always @(negedge clk) begin
        if (!nreset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold", 67'({pcs_head_o, pcs_data_o}), 67'(prev_out));
                chk("err_hold", 67'(pcs_err_o), 67'(0));
            end else if (pcs_valid_o) begin
                cur_err = pcs_err_o;
            end
            if (!mac_ready_o) begin
                low_cnt++;
                chk("rdy_b3", 67'(cur_beat), 67'(3));
            end
            prev_out = {pcs_head_o, pcs_data_o};
            hold_q   = pcs_valid_o & ~pcs_ready_i;
        end
    end

    initial begin
        nreset = 0;
        pcs_ready_i = 1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 67'(mac_ready_o), 67'(1));
        chk("rst_valid", 67'(pcs_valid_o), 67'(0));
        chk("rst_head", 67'(pcs_head_o), 67'(0));
        chk("rst_data", 67'(pcs_data_o), 67'(0));
        chk("rst_err", 67'(pcs_err_o), 67'(0));
        nreset = 1;

        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                send_blk(0, 0, 1, 0, 0, 64'h0, -1, 1);
                chk("idle_rdy", 67'(mac_ready_o), 67'(1));
                if (b == 0 && k == 2) chk("lat_pre", 67'(pcs_valid_o), 67'(0));
                if (b == 0 && k == 3) chk("lat_post", 67'(pcs_valid_o), 67'(1));
            end
            exp_blk(2'b10, IDLE_BLK, 0);
        end

        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(0, 0, 0, 0, 0, D1, -1, 4); exp_blk(2'b01, D1, 0);
        send_blk(0, 0, 0, 0, 0, D2, -1, 4); exp_blk(2'b01, D2, 0);
        send_blk(1, 0, 0, 1, 3, 64'hFFFFFFFFFFCCBBAA, -1, 4);
        exp_blk(2'b10, 64'h00000000CCBBAAB4, 0);

        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(1, 0, 0, 1, 0, 64'h1122334455667788, -1, 4);
        exp_blk(2'b10, 64'h87, 0);
        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(1, 0, 0, 1, 7, 64'hEE11223344556677, -1, 4);
        exp_blk(2'b10, 64'h11223344556677FF, 0);

        send_blk(0, 0, 0, 0, 0, D1, -1, 4); exp_blk(2'b10, ERR_BLK, 1);
        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, ERR_BLK, 1);

        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(0, 0, 0, 0, 0, D2, 2, 4);  exp_blk(2'b10, ERR_BLK, 1);
        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(1, 0, 0, 1, 9, D1, -1, 4); exp_blk(2'b10, ERR_BLK, 1);
        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        send_blk(0, 0, 1, 0, 0, 64'h0, -1, 4); exp_blk(2'b10, ERR_BLK, 1);
        send_blk(0, 0, 1, 0, 0, 64'h0, -1, 4); exp_blk(2'b10, IDLE_BLK, 0);

        send_blk(1, 1, 0, 0, 0, SP, -1, 4); exp_blk(2'b10, SP_ENC, 0);
        fork
            begin
                pcs_ready_i = 0;
                repeat (6) @(posedge clk);
                #1 pcs_ready_i = 1;
            end
            begin
                send_blk(0, 0, 0, 0, 0, D1, -1, 4);
                send_blk(0, 0, 0, 0, 0, D2, -1, 4);
            end
        join
        exp_blk(2'b01, D1, 0);
        exp_blk(2'b01, D2, 0);
        chk("stall_seen", 67'(low_cnt > 0), 67'(1));
        send_blk(1, 0, 0, 1, 2, 64'h000000000000BEEF, -1, 4);
        exp_blk(2'b10, 64'h0000000000BEEFAA, 0);
        send_blk(0, 0, 1, 0, 0, 64'h0, -1, 4); exp_blk(2'b10, IDLE_BLK, 0);
        send_blk(0, 0, 1, 0, 0, 64'h0, -1, 4);

        chk("nblk", 67'(got_q.size()), 67'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("blk%0d", i), got_q[i], exp_q[i]);
        end

        pcs_ready_i = 0;
        send_blk(1, 1, 0, 0, 0, SP, -1, 2);
        chk("pre_rst_valid", 67'(pcs_valid_o), 67'(1));
        nreset = 0;
        #1;
        chk("arst_valid", 67'(pcs_valid_o), 67'(0));
        chk("arst_head", 67'(pcs_head_o), 67'(0));
        chk("arst_data", 67'(pcs_data_o), 67'(0));
        chk("arst_err", 67'(pcs_err_o), 67'(0));
        chk("arst_rdy", 67'(mac_ready_o), 67'(1));
        pcs_ready_i = 1;
        idle_in();
        @(posedge clk);
        #1 nreset = 1;
        send_blk(0, 0, 1, 0, 0, 64'h0, -1, 4);
        chk("post_valid", 67'(pcs_valid_o), 67'(1));
        chk("post_blk", 67'({pcs_err_o, pcs_head_o, pcs_data_o}),
            {1'b0, 2'b10, IDLE_BLK});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
